// File: rtl/grid_row_loader.sv
// Purpose    : packs a stream of WORD_W-bit slices into X_SIZE-bit grid rows and
//              writes rows 0..Y_SIZE-1 in order into a grid-memory write port.
// Latency    : bram_we pulses for one cycle, the cycle after the last slice of a row is accepted.
// Backpressure: word_ready is high only while collecting; it is low in IDLE, WRITE and DONE.
//
// Ports:
//   out_stream_aclk  sole clock (rising edge)
//   periph_resetn    asynchronous active-low reset
//   start            one-cycle request to load a full grid, honoured in IDLE/DONE only
//   word_data/_valid input slice stream, left-most slice of a row first
//   word_ready       slice accepted on an edge where word_valid && word_ready
//   bram_addr/din/we grid-memory write port (row address, row data, one-cycle strobe)
//   busy             load in progress (COLLECT or WRITE)
//   done             last row written; held until the next accepted start
module grid_row_loader #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720,
  parameter int WORD_W = 32
) (
  input  logic                      out_stream_aclk,
  input  logic                      periph_resetn,
  input  logic                      start,
  input  logic [WORD_W-1:0]         word_data,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic [$clog2(Y_SIZE)-1:0] bram_addr,
  output logic [X_SIZE-1:0]         bram_din,
  output logic                      bram_we,
  output logic                      busy,
  output logic                      done
);

  localparam int WORDS_PER_ROW = X_SIZE / WORD_W;
  localparam int ADDR_W        = $clog2(Y_SIZE);
  localparam int WCNT_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ROW - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q,   row_d;
  logic [WCNT_W-1:0]   word_q,  word_d;
  logic [X_SIZE-1:0]   row_buf_q, row_buf_d;
  logic [X_SIZE-1:0]   row_shift;

  // Slices are shifted in from the LSB end. After WORDS_PER_ROW accepts the
  // first slice of the row has moved up to the MSBs and every bit of the
  // buffer has been overwritten, so no clearing between rows is needed.
  generate
    if (WORDS_PER_ROW > 1) begin : g_shift
      assign row_shift = {row_buf_q[X_SIZE-WORD_W-1:0], word_data};
    end else begin : g_single
      assign row_shift = word_data;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    row_buf_d  = row_buf_q;
    word_ready = 1'b0;
    bram_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d = COLLECT;
          row_d   = '0;
          word_d  = '0;
        end
      end

      COLLECT: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        // No valid word: everything holds, including the partial row.
        if (word_valid) begin
          row_buf_d = row_shift;
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = WRITE;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      WRITE: begin
        bram_we = 1'b1;
        busy    = 1'b1;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address and data come straight from the counters/buffer; neither can
  // change during WRITE because no word is accepted there.
  assign bram_addr = row_q;
  assign bram_din  = row_buf_q;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q   <= IDLE;
      row_q     <= '0;
      word_q    <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      word_q    <= word_d;
      row_buf_q <= row_buf_d;
    end
  end

endmodule

// File: tb/tb_grid_row_loader.sv
// Purpose : self-checking bench for grid_row_loader; expected row writes are
//           queued as words are driven and compared when bram_we is seen.
// Ports   : none (top-level bench).
module tb_grid_row_loader;

  localparam int X   = 1280;
  localparam int Y   = 720;
  localparam int W   = 32;
  localparam int WPR = X / W;
  localparam int AW  = $clog2(Y);

  logic          out_stream_aclk = 1'b0;
  logic          periph_resetn   = 1'b1;
  logic          start           = 1'b0;
  logic [W-1:0]  word_data       = '0;
  logic          word_valid      = 1'b0;
  logic          word_ready;
  logic [AW-1:0] bram_addr;
  logic [X-1:0]  bram_din;
  logic          bram_we;
  logic          busy;
  logic          done;

  grid_row_loader #(.X_SIZE(X), .Y_SIZE(Y), .WORD_W(W)) dut (
    .out_stream_aclk (out_stream_aclk),
    .periph_resetn   (periph_resetn),
    .start           (start),
    .word_data       (word_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .bram_addr       (bram_addr),
    .bram_din        (bram_din),
    .bram_we         (bram_we),
    .busy            (busy),
    .done            (done)
  );

  always #5 out_stream_aclk = ~out_stream_aclk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [X-1:0]  din;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  int           checks  = 0;
  int           errors  = 0;
  int           strobes = 0;
  logic [X-1:0] exp_din = '0;
  int           exp_k   = 0;
  int           exp_row = 0;
  bit           rand_gaps = 1'b0;

  // Write monitor: every strobe must match the next queued row.
  always @(negedge out_stream_aclk) begin
    if (periph_resetn && bram_we) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d, no write was due", bram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (bram_addr !== mon_e.addr || bram_din !== mon_e.din) begin
          errors++;
          $display("FAIL write_row got addr=%0d msw=%h lsw=%h want addr=%0d msw=%h lsw=%h",
                   bram_addr, bram_din[X-1 -: W], bram_din[W-1:0],
                   mon_e.addr, mon_e.din[X-1 -: W], mon_e.din[W-1:0]);
        end
      end
    end
  end

  // Drive one word; returns at the negedge after the edge that accepted it.
  task automatic send_word(input logic [W-1:0] d);
    int  guard;
    wr_t e;
    if (rand_gaps) begin
      while ($urandom_range(1) == 0) begin
        word_valid = 1'b0;
        @(negedge out_stream_aclk);
      end
    end
    word_valid = 1'b1;
    word_data  = d;
    guard      = 0;
    while (!word_ready && guard < 50) begin
      @(negedge out_stream_aclk);
      guard++;
    end
    if (!word_ready) begin
      checks++;
      errors++;
      $display("FAIL word_ready_timeout got word_ready=0 want 1 within 50 cycles");
      word_valid = 1'b0;
      return;
    end
    exp_din[X-1-exp_k*W -: W] = d;
    if (exp_k == WPR-1) begin
      e.addr = AW'(exp_row);
      e.din  = exp_din;
      exp_q.push_back(e);
      exp_k   = 0;
      exp_row = (exp_row + 1) % Y;
    end else begin
      exp_k++;
    end
    @(negedge out_stream_aclk);
    word_valid = 1'b0;
  endtask

  task automatic send_rand_words(input int n);
    for (int i = 0; i < n; i++) send_word($urandom());
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge out_stream_aclk);
    start   = 1'b0;
    exp_k   = 0;
    exp_row = 0;
  endtask

  task automatic quick_reset();
    periph_resetn = 1'b0;
    exp_q.delete();
    exp_k   = 0;
    exp_row = 0;
    @(negedge out_stream_aclk);
    @(negedge out_stream_aclk);
    periph_resetn = 1'b1;
    @(negedge out_stream_aclk);
  endtask

  task automatic test_reset();
    #2 periph_resetn = 1'b0;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got %b want 0", word_ready); end
    checks++; if (bram_we !== 1'b0)    begin errors++; $display("FAIL reset_bram_we got %b want 0", bram_we); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bram_addr !== '0)    begin errors++; $display("FAIL reset_bram_addr got %0d want 0", bram_addr); end
    checks++; if (bram_din !== '0)     begin errors++; $display("FAIL reset_bram_din got msw=%h want 0", bram_din[X-1 -: W]); end
    @(negedge out_stream_aclk);
    @(negedge out_stream_aclk);
    periph_resetn = 1'b1;
    @(negedge out_stream_aclk);
  endtask

  task automatic test_valid_when_idle(input string tag, input logic want_done);
    word_valid = 1'b1;
    word_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge out_stream_aclk);
      checks++;
      if (word_ready !== 1'b0 || bram_we !== 1'b0 || done !== want_done) begin
        errors++;
        $display("FAIL %s_valid_ignored got ready=%b we=%b done=%b want ready=0 we=0 done=%b",
                 tag, word_ready, bram_we, done, want_done);
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_all_ones();
    logic [X-1:0] ones;
    ones = '1;
    rand_gaps = 1'b0;
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
    for (int i = 0; i < WPR; i++) send_word('1);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== '0 || bram_din !== ones || busy !== 1'b1 || word_ready !== 1'b0) begin
      errors++;
      $display("FAIL ones_write_latency got we=%b addr=%0d busy=%b ready=%b want we=1 addr=0 busy=1 ready=0 din all ones",
               bram_we, bram_addr, busy, word_ready);
    end
    @(negedge out_stream_aclk);
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL we_one_cycle got %b want 0", bram_we); end
  endtask

  task automatic test_bit_order();
    logic [X-1:0] v;
    send_word(32'h8000_0000);
    for (int i = 1; i < WPR; i++) send_word('0);
    v = '0; v[X-1] = 1'b1;
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(1) || bram_din !== v) begin
      errors++;
      $display("FAIL msb_first got we=%b addr=%0d msw=%h lsw=%h want we=1 addr=1 msw=80000000 lsw=0",
               bram_we, bram_addr, bram_din[X-1 -: W], bram_din[W-1:0]);
    end
    for (int i = 0; i < WPR-1; i++) send_word('0);
    send_word(32'h0000_0001);
    v = '0; v[0] = 1'b1;
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(2) || bram_din !== v) begin
      errors++;
      $display("FAIL lsb_last got we=%b addr=%0d msw=%h lsw=%h want we=1 addr=2 msw=0 lsw=1",
               bram_we, bram_addr, bram_din[X-1 -: W], bram_din[W-1:0]);
    end
  endtask

  task automatic test_start_ignored();
    send_rand_words(2*WPR);          // rows 3 and 4
    send_rand_words(10);             // part of row 5
    start = 1'b1;                    // pulse while collecting
    @(negedge out_stream_aclk);
    start = 1'b0;
    send_rand_words(WPR-10);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(5)) begin
      errors++; $display("FAIL row5_after_start got we=%b addr=%0d want we=1 addr=5", bram_we, bram_addr);
    end
    start = 1'b1;                    // pulse during the WRITE cycle
    @(negedge out_stream_aclk);
    start = 1'b0;
    send_rand_words(WPR);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(6)) begin
      errors++; $display("FAIL row6_follows got we=%b addr=%0d want we=1 addr=6", bram_we, bram_addr);
    end
  endtask

  task automatic test_reset_midload();
    quick_reset();
    do_start();
    send_rand_words(3*WPR + 20);
    periph_resetn = 1'b0;
    exp_q.delete();
    exp_k   = 0;
    exp_row = 0;
    #1;
    checks++;
    if (word_ready !== 1'b0 || bram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bram_addr !== '0 || bram_din !== '0) begin
      errors++;
      $display("FAIL async_reset_midload got ready=%b we=%b busy=%b done=%b addr=%0d msw=%h want all 0",
               word_ready, bram_we, busy, done, bram_addr, bram_din[X-1 -: W]);
    end
    @(negedge out_stream_aclk);
    @(negedge out_stream_aclk);
    periph_resetn = 1'b1;
    @(negedge out_stream_aclk);
    do_start();
    send_rand_words(WPR);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== '0) begin
      errors++; $display("FAIL restart_row0 got we=%b addr=%0d want we=1 addr=0", bram_we, bram_addr);
    end
  endtask

  task automatic test_full_load();
    quick_reset();
    strobes   = 0;
    rand_gaps = 1'b1;
    do_start();
    send_rand_words(Y*WPR);
    rand_gaps = 1'b0;
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(Y-1)) begin
      errors++; $display("FAIL last_row_write got we=%b addr=%0d want we=1 addr=%0d", bram_we, bram_addr, Y-1);
    end
    @(negedge out_stream_aclk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL load_done got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    checks++;
    if (strobes !== Y || exp_q.size() != 0) begin
      errors++; $display("FAIL strobe_count got %0d pending=%0d want %0d pending=0", strobes, exp_q.size(), Y);
    end
  endtask

  task automatic test_done_restart();
    test_valid_when_idle("done", 1'b1);
    do_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_from_done got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    send_rand_words(WPR);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== '0) begin
      errors++; $display("FAIL done_restart_row0 got we=%b addr=%0d want we=1 addr=0", bram_we, bram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_valid_when_idle("idle", 1'b0);
    test_all_ones();
    test_bit_order();
    test_start_ignored();
    test_reset_midload();
    test_full_load();
    test_done_restart();
    @(negedge out_stream_aclk);
    @(negedge out_stream_aclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_writes got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_row_loader.md
GRID_ROW_LOADER -- requirements
Module: grid_row_loader

Interface
REQ-001 Parameter X_SIZE, default 1280, cells per grid row (BRAM word width).
REQ-002 Parameter Y_SIZE, default 720, rows per grid (BRAM depth).
REQ-003 Parameter WORD_W, default 32, input word width; X_SIZE SHALL be an integer multiple of WORD_W; WORDS_PER_ROW = X_SIZE/WORD_W (40 at defaults).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 out_stream_aclk  in  1  sole clock; all state changes on its rising edge.
REQ-006 periph_resetn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to begin loading a full grid from row 0.
REQ-008 word_data  in  WORD_W  next 32-cell slice of the current row, left-most slice first.
REQ-009 word_valid  in  1  word_data is valid this cycle.
REQ-010 word_ready  out  1  block accepts word_data this cycle.
REQ-011 bram_addr  out  clog2(Y_SIZE)  row address for the grid-memory write port.
REQ-012 bram_din  out  X_SIZE  assembled row data.
REQ-013 bram_we  out  1  single-cycle write strobe for the grid-memory write port.
REQ-014 busy  out  1  high while a load is in progress.
REQ-015 done  out  1  high after the final row is written; held until the next accepted start.

Function
REQ-016 States: IDLE, COLLECT, WRITE, DONE; IDLE is the reset state.
REQ-017 IDLE/DONE: start=1 -> COLLECT, row counter=0, word counter=0, done cleared the same edge.
REQ-018 start SHALL be ignored in COLLECT and WRITE.
REQ-019 word_ready=1 only in COLLECT; a word transfers on the edge where word_valid and word_ready are both 1.
REQ-020 Word k (k=0..WORDS_PER_ROW-1) of a row SHALL land at bram_din[X_SIZE-1-k*WORD_W -: WORD_W], so the first word occupies the MSBs.
REQ-021 word_valid=0 in COLLECT SHALL stall with no state change; counters and partial row held.
REQ-022 On transfer of word WORDS_PER_ROW-1 -> WRITE; word counter wraps to 0.
REQ-023 WRITE lasts exactly one cycle: bram_we=1, bram_addr=current row, bram_din=complete row; bram_din and bram_addr stable during it.
REQ-024 Write latency: bram_we asserts the cycle immediately after the last word of the row is accepted.
REQ-025 After WRITE: row<Y_SIZE-1 -> row+1, COLLECT; row=Y_SIZE-1 -> DONE, row counter wraps to 0.
REQ-026 bram_we SHALL be 0 in every state other than WRITE; exactly Y_SIZE write strobes per load.
REQ-027 busy=1 in COLLECT and WRITE, else 0; done=1 only in DONE.
REQ-028 Rows SHALL be written in strictly ascending order 0..Y_SIZE-1 with no skipped or repeated address.

Reset
REQ-029 periph_resetn=0 SHALL immediately, without a clock edge, force IDLE, counters=0, word_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0.
REQ-030 Reset asserted mid-load SHALL abandon the partial row with no write; a new start after release restarts from row 0.

Verification
REQ-031 Reset, start, 40 words 0xFFFFFFFF continuous valid -> bram_we one cycle after 40th accept, bram_addr=0, bram_din all ones, busy=1.
REQ-032 Row words 0x80000000 then 39x 0 -> bram_din[1279]=1, all other bits 0; words 0..38 zero, word 39=0x00000001 -> only bram_din[0]=1.
REQ-033 Full load 720x40 words with word_valid randomly low ~50% -> exactly 720 strobes, addresses 0..719 ascending, done=1, busy=0 after address 719 written.
REQ-034 start pulsed during COLLECT at row 5 -> ignored; row 6 still follows row 5; in DONE, start -> done=0, next write at bram_addr=0.
REQ-035 periph_resetn low after 20 words of row 3 -> all outputs 0 asynchronously, no write to row 3; restart -> first write at bram_addr=0.
REQ-036 word_valid high in IDLE and DONE -> word_ready=0, no word consumed, no bram_we.
